hnoc_rr_arbiter: RTL and testbench



---
 rtl/hnoc_rr_arbiter.sv | 96 +++++++++
 tb/tb_hnoc_rr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hnoc_rr_arbiter.sv
// rtl/hnoc_rr_arbiter.sv - four-requester round-robin flit arbiter with burst lock and registered output stage
module hnoc_rr_arbiter #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 2,
    parameter int numReq    = 4,
    parameter int IdWidth   = 2,
    parameter int MaxBurst  = 1
) (
    input  logic                                        i_clk,
    input  logic                                        i_reset,
    input  logic [numReq*(DataWidth+AddrWidth)-1:0]     i_req_data,
    input  logic [numReq-1:0]                           i_req_valid,
    output logic [numReq-1:0]                           o_req_ready,
    output logic [DataWidth+AddrWidth-1:0]              o_data,
    output logic                                        o_data_valid,
    input  logic                                        i_data_ready,
    output logic [IdWidth-1:0]                          o_grant_id
);

    localparam int W = DataWidth + AddrWidth;
    localparam logic [3:0] MAX_BURST = 4'(MaxBurst);
    localparam logic [IdWidth-1:0] LAST_REQ = IdWidth'(numReq - 1);

    logic [IdWidth-1:0] owner;
    logic [3:0]         cnt;
    logic [IdWidth-1:0] sel;
    logic               free;
    logic               any_valid;
    logic               lock;
    logic               accept;
    logic [W-1:0]       flits [numReq];

    assign free      = !o_data_valid || i_data_ready;
    assign any_valid = |i_req_valid;
    assign accept    = free && any_valid;
    assign lock      = (cnt < MAX_BURST) && i_req_valid[owner] && (cnt != 4'd0);

    always_comb begin
        for (int k = 0; k < numReq; k++) begin
            flits[k] = i_req_data[k*W +: W];
        end
    end

    // Search starts just past the owner and wraps so the owner is considered last.
    always_comb begin
        logic               found;
        logic [IdWidth-1:0] cand;
        int                 idx;
        sel   = owner;
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        if (!lock) begin
            for (int i = 1; i <= numReq; i++) begin
                idx  = (int'(owner) + i) % numReq;
                cand = IdWidth'(idx);
                if (!found && i_req_valid[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (accept && !i_reset) begin
            o_req_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_grant_id   <= '0;
            owner        <= LAST_REQ;
            cnt          <= 4'd0;
        end else if (accept) begin
            o_data       <= flits[sel];
            o_data_valid <= 1'b1;
            o_grant_id   <= sel;
            if (lock) begin
                cnt <= cnt + 4'd1;
            end else begin
                owner <= sel;
                cnt   <= 4'd1;
            end
        end else if (free) begin
            // Idle link: drop the stage and release any burst lock.
            o_data_valid <= 1'b0;
            cnt          <= 4'd0;
        end
    end

endmodule

// File: tb/tb_hnoc_rr_arbiter.sv
// tb/tb_hnoc_rr_arbiter.sv - self-checking bench for hnoc_rr_arbiter at MaxBurst 1 and 3
module tb_hnoc_rr_arbiter;

    localparam int W = 34;

    logic              clk;
    logic              rst;
    logic [4*W-1:0]    req_data;
    logic [3:0]        req_valid;
    logic              data_ready;
    logic [3:0]        rdy [2];
    logic [W-1:0]      dat [2];
    logic              dv  [2];
    logic [1:0]        gid [2];

    int n_cmp;
    int n_err;

    int          m_owner [2];
    int          m_cnt   [2];
    logic [W-1:0] m_data [2];
    logic        m_valid [2];
    int          m_gid   [2];

    hnoc_rr_arbiter #(.MaxBurst(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_req_data(req_data), .i_req_valid(req_valid),
        .o_req_ready(rdy[0]), .o_data(dat[0]), .o_data_valid(dv[0]),
        .i_data_ready(data_ready), .o_grant_id(gid[0])
    );

    hnoc_rr_arbiter #(.MaxBurst(3)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_req_data(req_data), .i_req_valid(req_valid),
        .o_req_ready(rdy[1]), .o_data(dat[1]), .o_data_valid(dv[1]),
        .i_data_ready(data_ready), .o_grant_id(gid[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int mb(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = 3;
            m_cnt[d]   = 0;
            m_data[d]  = '0;
            m_valid[d] = 1'b0;
            m_gid[d]   = 0;
        end
    endtask

    function automatic logic model_locked(int d);
        return (m_cnt[d] != 0) && (m_cnt[d] < mb(d)) && req_valid[m_owner[d]];
    endfunction

    // Winner by the rotation rule: burst owner first, else first valid after the owner.
    function automatic int model_sel(int d);
        if (model_locked(d)) return m_owner[d];
        for (int s = 1; s <= 4; s++) begin
            if (req_valid[(m_owner[d] + s) % 4]) return (m_owner[d] + s) % 4;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] flit_of(int k);
        return req_data[k*W +: W];
    endfunction

    task automatic set_flit(input int k, input logic [W-1:0] v);
        req_data[k*W +: W] = v;
    endtask

    task automatic step();
        int       s    [2];
        logic     lk   [2];
        logic     acc  [2];
        logic     fr   [2];
        logic [3:0] er;
        #1;
        for (int d = 0; d < 2; d++) begin
            s[d]   = model_sel(d);
            lk[d]  = model_locked(d);
            fr[d]  = !m_valid[d] || data_ready;
            acc[d] = fr[d] && (s[d] >= 0);
            er     = acc[d] ? (4'b0001 << s[d]) : 4'b0000;
            chk($sformatf("ready_mb%0d", mb(d)), 64'(rdy[d]), 64'(er));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (acc[d]) begin
                m_data[d]  = flit_of(s[d]);
                m_valid[d] = 1'b1;
                m_gid[d]   = s[d];
                if (lk[d]) m_cnt[d]++;
                else begin
                    m_owner[d] = s[d];
                    m_cnt[d]   = 1;
                end
            end else if (fr[d]) begin
                m_valid[d] = 1'b0;
                m_cnt[d]   = 0;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("data_mb%0d", mb(d)), 64'(dat[d]), 64'(m_data[d]));
            chk($sformatf("valid_mb%0d", mb(d)), 64'(dv[d]), 64'(m_valid[d]));
            chk($sformatf("gid_mb%0d", mb(d)), 64'(gid[d]), 64'(m_gid[d]));
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int burst_seq [9];
        logic [W-1:0] exp_flit;
        burst_seq = '{0, 0, 0, 2, 2, 2, 0, 0, 0};
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        req_data = '0;
        req_valid = 4'h0;
        data_ready = 1'b1;
        model_reset();

        // Reset and idle: ready stays low during reset even with requests pending.
        repeat (3) @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", 64'(rdy[d]), 64'h0);
            chk("reset_data", 64'(dat[d]), 64'h0);
            chk("reset_valid", 64'(dv[d]), 64'h0);
            chk("reset_gid", 64'(gid[d]), 64'h0);
        end
        req_valid = 4'h0;
        rst = 1'b0;
        repeat (5) step();

        // Fair rotation with all four requesters valid.
        for (int k = 0; k < 4; k++) set_flit(k, {2'b00, 32'hAAAA0000 + 32'(k)});
        req_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_flit = {2'b00, 32'hAAAA0000 + 32'(i % 4)};
            chk("rotate_gid", 64'(gid[0]), 64'(i % 4));
            chk("rotate_data", 64'(dat[0]), 64'(exp_flit));
        end

        // Burst lock with requesters 0 and 2.
        apply_reset();
        req_valid = 4'b0101;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("burst_gid", 64'(gid[1]), 64'(burst_seq[i]));
        end
        apply_reset();
        req_valid = 4'b0101;
        repeat (2) step();
        req_valid = 4'b0100;
        step();
        chk("burst_drop_gid", 64'(gid[1]), 64'd2);

        // Backpressure on a held flit.
        set_flit(3, {2'b11, 32'hDEADBEEF});
        req_valid = 4'b1000;
        step();
        req_valid = 4'b1011;
        data_ready = 1'b0;
        repeat (3) begin
            step();
            chk("stall_hold", 64'(dat[0]), 64'h3DEADBEEF);
        end
        data_ready = 1'b1;
        step();
        chk("stall_release_valid", 64'(dv[1]), 64'h1);

        // Single streamer: no bubbles.
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            set_flit(1, W'({$urandom, $urandom}));
            step();
            chk("stream_gid", 64'(gid[1]), 64'd1);
            chk("stream_valid", 64'(dv[1]), 64'h1);
        end

        // Reset asserted asynchronously while stalled.
        req_valid = 4'b1000;
        step();
        data_ready = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_reset_valid", 64'(dv[d]), 64'h0);
            chk("async_reset_data", 64'(dat[d]), 64'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 4'hF;
        data_ready = 1'b1;
        step();
        chk("post_reset_gid", 64'(gid[0]), 64'd0);
        chk("post_reset_gid3", 64'(gid[1]), 64'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) set_flit(k, W'({$urandom, $urandom}));
            req_valid  = 4'($urandom_range(0, 15));
            data_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
